// File: rtl/usart_tx_arbiter_if.sv
// Requester-side and usart_tx-side handshake bundle for usart_tx_arbiter.
// The slave modport is the arbiter's view; master is the view of the surrounding logic.
interface usart_tx_arbiter_if #(
    parameter int unsigned NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_last;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ-1:0]   grant;
    logic [7:0]           tx_data_in;
    logic                 tx_valid;
    logic                 tx_ready;
    logic                 tx_done;
    logic                 busy;
    logic                 timeout_evt;

    modport slave (
        input  req_valid, req_last, req_data, tx_ready, tx_done,
        output req_ready, grant, tx_data_in, tx_valid, busy, timeout_evt
    );

    modport master (
        output req_valid, req_last, req_data, tx_ready, tx_done,
        input  req_ready, grant, tx_data_in, tx_valid, busy, timeout_evt
    );
endinterface

// File: rtl/usart_tx_arbiter.sv
// Message-locking arbiter sharing one usart_tx among NUM_REQ byte-stream requesters.
// Optional `define USART_ARB_FIXED_PRIORITY_EN: lowest index wins in IDLE, no round-robin pointer.
module usart_tx_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned LOCK_TIMEOUT = 1024
) (
    input  logic              comm_clock,
    input  logic              reset,
    usart_tx_arbiter_if.slave bus
);
    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_WAIT_DONE,
        S_HOLD
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [NUM_REQ-1:0] r_grant;
    logic [NUM_REQ-1:0] w_grant_nxt;
    logic [NUM_REQ-1:0] r_req_ready;
    logic [NUM_REQ-1:0] w_req_ready_nxt;
    logic [7:0]         r_tx_data;
    logic [7:0]         w_tx_data_nxt;
    logic               r_tx_valid;
    logic               w_tx_valid_nxt;
    logic               r_busy;
    logic               r_timeout;
    logic               w_timeout_nxt;
    logic               r_last;
    logic               w_last_nxt;
    logic [IDX_W-1:0]   r_owner;
    logic [IDX_W-1:0]   w_owner_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [IDX_W-1:0]   w_winner;
    logic               w_any_valid;
    logic               w_owner_valid;
    logic               w_owner_last;
    logic [7:0]         w_owner_data;
    logic               w_winner_last;
    logic [7:0]         w_winner_data;
    logic               w_cnt_expired;
`ifndef USART_ARB_FIXED_PRIORITY_EN
    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   w_ptr_nxt;
    logic [IDX_W-1:0]   w_owner_inc;
`endif

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_REQ-1:0] oh;
        for (int k = 0; k < NUM_REQ; k++) begin
            oh[k] = (IDX_W'(k) == idx);
        end
        return oh;
    endfunction

    function automatic logic bit_at(input logic [NUM_REQ-1:0] v, input logic [IDX_W-1:0] idx);
        logic b;
        b = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (IDX_W'(k) == idx) b = v[k];
        end
        return b;
    endfunction

    function automatic logic [7:0] byte_at(input logic [8*NUM_REQ-1:0] d, input logic [IDX_W-1:0] idx);
        logic [7:0] b;
        b = 8'h00;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (IDX_W'(k) == idx) b = d[8*k +: 8];
        end
        return b;
    endfunction

    // IDLE winner selection
`ifdef USART_ARB_FIXED_PRIORITY_EN
    always_comb begin
        w_winner = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (bus.req_valid[k]) w_winner = IDX_W'(k);
        end
    end
`else
    // Descending scan so the smallest offset from the pointer is the last (winning) hit
    always_comb begin
        int idx;
        w_winner = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(r_ptr) + k;
            if (idx >= int'(NUM_REQ)) idx = idx - int'(NUM_REQ);
            if (bit_at(bus.req_valid, IDX_W'(idx))) w_winner = IDX_W'(idx);
        end
    end

    assign w_owner_inc = (r_owner == IDX_W'(NUM_REQ - 1)) ? '0 : r_owner + IDX_W'(1);
`endif

    assign w_any_valid   = |bus.req_valid;
    assign w_owner_valid = bit_at(bus.req_valid, r_owner);
    assign w_owner_last  = bit_at(bus.req_last, r_owner);
    assign w_owner_data  = byte_at(bus.req_data, r_owner);
    assign w_winner_last = bit_at(bus.req_last, w_winner);
    assign w_winner_data = byte_at(bus.req_data, w_winner);
    assign w_cnt_expired = (r_cnt == CNT_W'(LOCK_TIMEOUT - 1));

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt     = r_state;
        w_grant_nxt     = r_grant;
        w_req_ready_nxt = '0;
        w_tx_data_nxt   = r_tx_data;
        w_tx_valid_nxt  = r_tx_valid;
        w_timeout_nxt   = 1'b0;
        w_last_nxt      = r_last;
        w_owner_nxt     = r_owner;
        w_cnt_nxt       = r_cnt;
`ifndef USART_ARB_FIXED_PRIORITY_EN
        w_ptr_nxt       = r_ptr;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_any_valid) begin
                    w_owner_nxt     = w_winner;
                    w_grant_nxt     = onehot(w_winner);
                    w_req_ready_nxt = onehot(w_winner);
                    w_tx_data_nxt   = w_winner_data;
                    w_last_nxt      = w_winner_last;
                    w_tx_valid_nxt  = 1'b1;
                    w_state_nxt     = S_SEND;
                end
            end
            S_SEND: begin
                if (bus.tx_ready) begin
                    w_tx_valid_nxt = 1'b0;
                    w_state_nxt    = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (bus.tx_done) begin
                    if (r_last) begin
                        w_grant_nxt = '0;
`ifndef USART_ARB_FIXED_PRIORITY_EN
                        w_ptr_nxt   = w_owner_inc;
`endif
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                // Owner's valid takes precedence over an expiring count
                if (w_owner_valid) begin
                    w_req_ready_nxt = r_grant;
                    w_tx_data_nxt   = w_owner_data;
                    w_last_nxt      = w_owner_last;
                    w_tx_valid_nxt  = 1'b1;
                    w_cnt_nxt       = '0;
                    w_state_nxt     = S_SEND;
                end else if (w_cnt_expired) begin
                    w_timeout_nxt = 1'b1;
                    w_grant_nxt   = '0;
`ifndef USART_ARB_FIXED_PRIORITY_EN
                    w_ptr_nxt     = w_owner_inc;
`endif
                    w_state_nxt   = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_grant_nxt    = '0;
                w_tx_valid_nxt = 1'b0;
                w_state_nxt    = S_IDLE;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge comm_clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_grant     <= '0;
            r_req_ready <= '0;
            r_tx_data   <= 8'h00;
            r_tx_valid  <= 1'b0;
            r_busy      <= 1'b0;
            r_timeout   <= 1'b0;
            r_last      <= 1'b0;
            r_owner     <= '0;
            r_cnt       <= '0;
`ifndef USART_ARB_FIXED_PRIORITY_EN
            r_ptr       <= '0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_grant     <= w_grant_nxt;
            r_req_ready <= w_req_ready_nxt;
            r_tx_data   <= w_tx_data_nxt;
            r_tx_valid  <= w_tx_valid_nxt;
            r_busy      <= (w_state_nxt != S_IDLE);
            r_timeout   <= w_timeout_nxt;
            r_last      <= w_last_nxt;
            r_owner     <= w_owner_nxt;
            r_cnt       <= w_cnt_nxt;
`ifndef USART_ARB_FIXED_PRIORITY_EN
            r_ptr       <= w_ptr_nxt;
`endif
        end
    end

    assign bus.req_ready   = r_req_ready;
    assign bus.grant       = r_grant;
    assign bus.tx_data_in  = r_tx_data;
    assign bus.tx_valid    = r_tx_valid;
    assign bus.busy        = r_busy;
    assign bus.timeout_evt = r_timeout;
endmodule
